// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: NOP encoding, fetch FSM states and the buffered entry layout.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

package fetch_unit_pkg;
  localparam logic [31:0] INST_NOP_WORD = `INST_NOP;
  localparam int unsigned ENTRY_W = 65;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst, fault} entries; storage is not reset.
module fetch_fifo #(
  parameter int DATA_W = 65,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding request FSM with credit, redirect/flush handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = FIFO_DEPTH[CNT_W:0];

  fetch_state_t     state;
  logic [31:0]      pc;
  logic [31:0]      redirect_aligned;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   pending;
  logic             credit;
  logic             req_fire;
  logic             push;
  logic             deq;
  fetch_entry_t     enq;
  fetch_entry_t     head;

  // Credit counts buffered entries plus the one response still owed by memory.
  assign pending          = {1'b0, count} + {{CNT_W{1'b0}}, (state == WAIT)};
  assign credit           = pending < DEPTH_L;
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  assign imem_req_valid = !rst && (state == REQ) && credit;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = (state == WAIT) && imem_resp_valid && !redirect_valid;
  assign deq            = inst_valid && inst_ready;

  assign enq = '{pc: pc, inst: imem_resp_data, fault: imem_resp_err};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REQ;
      pc    <= {RESET_PC[31:2], 2'b00};
    end else if (redirect_valid) begin
      pc <= redirect_aligned;
      // A response is still owed if one was just requested or none has arrived yet.
      if (req_fire || (((state == WAIT) || (state == DROP)) && !imem_resp_valid))
        state <= DROP;
      else
        state <= REQ;
    end else begin
      case (state)
        REQ: if (req_fire) state <= WAIT;
        WAIT: begin
          if (imem_resp_valid) begin
            if (imem_resp_err) begin
              state <= HALT;
            end else begin
              pc    <= pc + 32'd4;
              state <= REQ;
            end
          end
        end
        DROP: if (imem_resp_valid) state <= REQ;
        HALT: state <= HALT;
        default: state <= REQ;
      endcase
    end
  end

  fetch_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (deq),
    .din   (enq),
    .dout  (head),
    .count (count)
  );

  assign inst_valid = (count != '0);
  assign inst_o     = (inst_valid && !head.fault) ? head.inst : INST_NOP_WORD;
  assign inst_pc    = inst_valid ? head.pc : 32'h0;
  assign inst_fault = inst_valid && head.fault;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the decoder. Holds the architectural fetch PC, issues one word-aligned read at a time to instruction memory, and buffers returned instructions with their PCs in a small FIFO. Downstream takes them over a valid/ready handshake. Redirects from execute/trap logic flush the FIFO and discard any in-flight response.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: fetch address after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries. Power of two, at least 2.

Ports (clock: `clk`; reset: `rst`, asynchronous, active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 32: word address. `[1:0]` is always `2'b00`.
- `imem_resp_valid` in 1: response present. One cycle per accepted request, in order.
- `imem_resp_data` in 32: instruction word.
- `imem_resp_err` in 1: access fault for this response.
- `redirect_valid` in 1: change fetch PC (branch, jump, trap, mret).
- `redirect_pc` in 32: new PC. Bits `[1:0]` are ignored and treated as 0.
- `inst_valid` out 1: `inst_o`, `inst_pc` and `inst_fault` are valid.
- `inst_ready` in 1: consumer accepts.
- `inst_o` out 32: instruction. Equals `` `INST_NOP `` when the FIFO is empty or when `inst_fault` is 1.
- `inst_pc` out 32: PC of `inst_o`.
- `inst_fault` out 1: instruction access fault for this PC.

## Operation
- State machine `fetch_state_t`:
  - REQ: drive a request.
  - WAIT: one request accepted, response pending.
  - DROP: discard the next response.
  - HALT: fault queued; wait for redirect.
- Credit: a request is driven in REQ only if `count + (state==WAIT) < FIFO_DEPTH`. The FIFO never overflows, and memory response backpressure does not exist.
- REQ:
  - `imem_req_valid = credit`, `imem_req_addr = pc`.
  - On `valid & ready`, go to WAIT. `pc` is not advanced yet.
- WAIT: on `imem_resp_valid`:
  - Enqueue `{pc, data, err}`.
  - If `err`, go to HALT with `pc` held.
  - Otherwise `pc <= pc + 4` (32-bit wrap; `32'hFFFF_FFFC + 4` = 0) and go to REQ.
  - The next request may be driven the following cycle.
- Priority: `redirect_valid` overrides everything in the same cycle:
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - FIFO cleared. A simultaneous dequeue still counts as consumed.
  - Any response arriving this cycle is discarded.
  - Next state:
    - DROP, if in WAIT without a response this cycle, or if a request is accepted this same cycle.
    - REQ, otherwise (including from HALT or DROP-with-response).
  - A not-yet-accepted request in REQ is simply withdrawn. The memory interface permits `valid` deassertion on redirect.
- DROP:
  - No request is driven.
  - The next `imem_resp_valid` is discarded; go to REQ.
  - A further redirect while in DROP updates `pc` and stays in DROP.
- HALT:
  - No requests.
  - The fault entry drains normally.
  - Exit only by redirect.
- Output: `inst_valid = count != 0`. The head entry is dequeued on `inst_valid & inst_ready`.

## Timing
- Reset values:
  - `pc = RESET_PC`, state REQ, FIFO empty.
  - `inst_valid = 0`, `inst_o = ` `` `INST_NOP ``, `inst_pc = 0`, `inst_fault = 0`.
  - `imem_req_valid` is 0 while `rst` is high, and 1 in the first cycle after deassertion.
- Response to output: a response in cycle N gives `inst_valid` in cycle N+1. The FIFO is registered with no bypass.
- Throughput: one instruction per 2 cycles with single-cycle memory. Back-to-back requests are not overlapped.
- Redirect to request: redirect in cycle N gives a request for the new PC in cycle N+1 (not in DROP), or in the cycle after the dropped response.
- Full FIFO with simultaneous enqueue and dequeue cannot occur: credit excludes it. Enqueue and dequeue in the same cycle with `count` between 1 and `FIFO_DEPTH-1` leave `count` unchanged.
- Reset asserted mid-transaction: everything returns to reset values immediately. A memory response arriving after reset release with no request issued is ignored in REQ.

## Structure
- Shared `defs.sv`:
  - `` `INST_NOP `` (`32'h0000_0013`).
  - `fetch_state_t` enum (REQ, WAIT, DROP, HALT).
- Sub-module `fetch_fifo`: synchronous FIFO, parameterized width and depth.
  - Ports: `clk`, `rst`, `flush`, `push`, `pop`, `din`, `dout`, `count`.
  - Width is 65 bits: pc, inst, fault.
- `fetch_unit` contains the PC register, state machine, credit logic and redirect handling.

## Test plan
- Reset release, memory always ready with 1-cycle response, `inst_ready=1`: requests go to `8000_0000`, `8000_0004`, `8000_0008`. `inst_pc` sequence matches, `inst_valid` every other cycle.
- `inst_ready=0`, FIFO_DEPTH 2:
  - Exactly two requests are issued, then `imem_req_valid=0`.
  - Raising `inst_ready` yields PCs `8000_0000` then `8000_0004`, then fetching resumes at `8000_0008`.
- Redirect to `0000_1002` in WAIT:
  - The pending response is dropped; the next request is to `0000_1000`.
  - `8000_xxxx` entries never appear after the redirect cycle.
- `imem_resp_err=1` at `8000_0004`:
  - Output shows `inst_fault=1`, `inst_pc=8000_0004`, `inst_o=`` `INST_NOP ``, then no more requests.
  - Redirect to `8000_0100` resumes fetching there.
- Wrap and corner cases:
  - Redirect to `FFFF_FFFC` gives next PC `0000_0000`.
  - Redirect coinciding with a response, or with a dequeue, empties the FIFO the next cycle.
  - Async `rst` mid-WAIT clears all outputs within the same cycle.
